// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pkg
//  Description : Shared types and constants for the 4-port round-robin
//                packet multiplexer and its pointer-pick helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_pkg;

    // Number of ports every RR stage in this family handles.
    localparam int unsigned RR_NPORTS = 4;

    // Packet-mux arbitration state.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } pktmux_state_e;

    // Two-bit port index; arithmetic on it wraps 3 -> 0 naturally.
    typedef logic [1:0] port_idx_t;

    // Port that follows a given port in round-robin order.
    function automatic port_idx_t rr_next(input port_idx_t idx);
        return idx + port_idx_t'(1);
    endfunction

endpackage : rr_pkg
`default_nettype wire

// File: rtl/rr4_ptr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr4_ptr_pick
//  Description : Combinational rotating-priority search over a 4-bit request
//                vector. Returns the first set request at or after ptr,
//                wrapping modulo 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr4_ptr_pick
    import rr_pkg::*;
(
    input  logic [RR_NPORTS-1:0] req,
    input  port_idx_t            ptr,
    output logic                 found,
    output port_idx_t            idx
);

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        found = |req;
        idx   = ptr;
        for (int i = RR_NPORTS - 1; i >= 0; i--) begin
            if (req[ptr + port_idx_t'(i)]) begin
                idx = ptr + port_idx_t'(i);
            end
        end
    end

endmodule : rr4_ptr_pick
`default_nettype wire

// File: rtl/rr4_pkt_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr4_pkt_mux
//  Description : 4-input packet multiplexer. Round-robin arbitration with
//                packet lock: the winning source owns the registered output
//                stream until its last beat is accepted. One idle bubble per
//                packet is spent on arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr4_pkt_mux
    import rr_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned NPORTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPORTS-1:0]    in_valid,
    output logic [NPORTS-1:0]    in_ready,
    input  logic [DW-1:0]        in_data [NPORTS],
    input  logic [NPORTS-1:0]    in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_last,
    output logic [1:0]           out_src,
    output logic                 busy
);

    // The port-index type and the pick helper are hard-wired for four ports.
    if (NPORTS != RR_NPORTS) begin : g_nports_bad
        $error("rr4_pkt_mux supports exactly 4 ports");
    end

    // ------------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------------
    pktmux_state_e state_q, state_d;
    port_idx_t     ptr_q,   ptr_d;     // round-robin start point
    port_idx_t     sel_q,   sel_d;     // current packet owner

    // Output register
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          out_last_q,  out_last_d;
    port_idx_t     out_src_q,   out_src_d;

    // Pick result and selected-source view
    logic          pick_found;
    port_idx_t     pick_idx;
    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;
    logic          sel_ready;
    logic          in_hs;
    logic          pkt_done;

    rr4_ptr_pick u_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Input mux: everything downstream only ever looks at the owning source.
    always_comb begin
        sel_valid = in_valid[sel_q];
        sel_last  = in_last[sel_q];
        sel_data  = in_data[sel_q];
    end

    // The output register can take a beat when empty or being drained.
    always_comb begin
        sel_ready = !out_valid_q || out_ready;
        in_hs     = (state_q == LOCKED) && sel_valid && sel_ready;
        pkt_done  = in_hs && sel_last;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Arbitration state, pointer and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // Lock onto the round-robin winner; release and advance ptr on last beat.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Other requesters are ignored; a stalled owner simply waits.
                if (pkt_done) begin
                    ptr_d   = rr_next(sel_q);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // Only the owner sees ready, and only while locked.
    always_comb begin
        in_ready = '0;
        busy     = (state_q == LOCKED);
        if (state_q == LOCKED) begin
            in_ready[sel_q] = sel_ready;
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    // Load on handshake (also covers load-while-draining), else drain or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (in_hs) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = sel_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output beat register; cleared asynchronously so partial packets vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule : rr4_pkt_mux
`default_nettype wire

// File: tb/tb_rr4_pkt_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr4_pkt_mux
//  Description : Directed self-checking bench for rr4_pkt_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr4_pkt_mux;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [DW-1:0] in_data [4];
    logic [3:0]    in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_src;
    logic          busy;

    int n_pass;
    int n_total;

    rr4_pkt_mux #(.DW(DW), .NPORTS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Registered outputs are only compared for content when a beat is expected.
    task automatic check_outs(input string tag, input logic ev, input logic [31:0] ed,
                              input logic el, input logic [1:0] es,
                              input logic [3:0] erdy, input logic eb);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".in_ready"},  32'(in_ready),  32'(erdy));
        check({tag, ".busy"},      32'(busy),      32'(eb));
        if (ev) begin
            check({tag, ".out_data"}, out_data,        ed);
            check({tag, ".out_last"}, 32'(out_last),   32'(el));
            check({tag, ".out_src"},  32'(out_src),    32'(es));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"},  out_data,       32'd0);
        check({tag, ".out_last"},  32'(out_last),  32'd0);
        check({tag, ".out_src"},   32'(out_src),   32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    task automatic clear_inputs();
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) in_data[j] = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Land 1 time unit after the active edge; inputs for the new cycle go here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b1;
        clear_inputs();
        out_ready = 1'b0;
        #2 rst_n = 1'b0;

        // ---- 1: reset with random inputs, then idle ----
        for (int k = 0; k < 3; k++) begin
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            out_ready = 1'($urandom);
            for (int j = 0; j < 4; j++) in_data[j] = $urandom;
            @(posedge clk);
            #1;
            check_reset("t1_rst");
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            #1;
            check_outs("t1_idle", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
        end

        // ---- 2: port 2 sends A0,A1,A2 ----
        do_reset();
        next_cycle();
        in_valid = 4'b0100; in_data[2] = 32'hA000_0000; in_last = 4'b0000;
        #1 check_outs("t2_c0", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t2_c1", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0100, 1'b1);
        next_cycle();
        in_data[2] = 32'hA000_0001;
        #1 check_outs("t2_c2", 1'b1, 32'hA000_0000, 1'b0, 2'd2, 4'b0100, 1'b1);
        next_cycle();
        in_data[2] = 32'hA000_0002; in_last = 4'b0100;
        #1 check_outs("t2_c3", 1'b1, 32'hA000_0001, 1'b0, 2'd2, 4'b0100, 1'b1);
        next_cycle();
        in_valid = 4'b0000; in_last = 4'b0000;
        #1 check_outs("t2_c4", 1'b1, 32'hA000_0002, 1'b1, 2'd2, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t2_c5", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);

        // ---- 3: all four ports stream single-beat packets ----
        do_reset();
        next_cycle();
        in_valid = 4'hF; in_last = 4'hF;
        for (int j = 0; j < 4; j++) in_data[j] = 32'hC0DE_0000 + 32'(j);
        #1 check_outs("t3_c0", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t3_c1", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0001, 1'b1);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            #1 check_outs("t3_beat", 1'b1, 32'hC0DE_0000 + 32'(k % 4), 1'b1,
                          2'(k % 4), 4'b0000, 1'b0);
            next_cycle();
            #1 check_outs("t3_gap", 1'b0, 32'd0, 1'b0, 2'd0,
                          4'(1 << ((k + 1) % 4)), 1'b1);
        end

        // ---- 4: lock, port 1 waits for port 0's 4-beat packet ----
        do_reset();
        next_cycle();
        in_valid = 4'b0001; in_data[0] = 32'hB000_0000; in_last = 4'b0000;
        #1 check_outs("t4_c0", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t4_c1", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0001, 1'b1);
        next_cycle();
        in_data[0] = 32'hB000_0001;
        in_valid = 4'b0011; in_data[1] = 32'h1111_1111; in_last = 4'b0010;
        #1 check_outs("t4_c2", 1'b1, 32'hB000_0000, 1'b0, 2'd0, 4'b0001, 1'b1);
        next_cycle();
        in_data[0] = 32'hB000_0002;
        #1 check_outs("t4_c3", 1'b1, 32'hB000_0001, 1'b0, 2'd0, 4'b0001, 1'b1);
        next_cycle();
        in_data[0] = 32'hB000_0003; in_last = 4'b0011;
        #1 check_outs("t4_c4", 1'b1, 32'hB000_0002, 1'b0, 2'd0, 4'b0001, 1'b1);
        next_cycle();
        in_valid = 4'b0010; in_last = 4'b0010;
        #1 check_outs("t4_c5", 1'b1, 32'hB000_0003, 1'b1, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t4_c6", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0010, 1'b1);
        next_cycle();
        in_valid = 4'b0000; in_last = 4'b0000;
        #1 check_outs("t4_c7", 1'b1, 32'h1111_1111, 1'b1, 2'd1, 4'b0000, 1'b0);

        // ---- 5: backpressure mid-packet on port 1 ----
        do_reset();
        next_cycle();
        in_valid = 4'b0010; in_data[1] = 32'hD000_0000; in_last = 4'b0000;
        #1 check_outs("t5_c0", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t5_c1", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0010, 1'b1);
        next_cycle();
        in_data[1] = 32'hD000_0001; out_ready = 1'b0;
        #1 check_outs("t5_stall0", 1'b1, 32'hD000_0000, 1'b0, 2'd1, 4'b0000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            #1 check_outs("t5_stall", 1'b1, 32'hD000_0000, 1'b0, 2'd1, 4'b0000, 1'b1);
        end
        next_cycle();
        out_ready = 1'b1;
        #1 check_outs("t5_c5", 1'b1, 32'hD000_0000, 1'b0, 2'd1, 4'b0010, 1'b1);
        next_cycle();
        in_data[1] = 32'hD000_0002; in_last = 4'b0010;
        #1 check_outs("t5_c6", 1'b1, 32'hD000_0001, 1'b0, 2'd1, 4'b0010, 1'b1);
        next_cycle();
        in_valid = 4'b0000; in_last = 4'b0000;
        #1 check_outs("t5_c7", 1'b1, 32'hD000_0002, 1'b1, 2'd1, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t5_c8", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);

        // ---- 6: asynchronous reset mid-packet from port 3 ----
        do_reset();
        next_cycle();
        in_valid = 4'b1000; in_data[3] = 32'hE000_0000; in_last = 4'b0000;
        #1 check_outs("t6_c0", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t6_c1", 1'b0, 32'd0, 1'b0, 2'd0, 4'b1000, 1'b1);
        next_cycle();
        in_data[3] = 32'hE000_0001;
        #1 check_outs("t6_c2", 1'b1, 32'hE000_0000, 1'b0, 2'd3, 4'b1000, 1'b1);
        next_cycle();
        in_data[3] = 32'hE000_0002;
        #1 check_outs("t6_c3", 1'b1, 32'hE000_0001, 1'b0, 2'd3, 4'b1000, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_reset("t6_async");
        in_data[3] = 32'hF000_000F; in_last = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        #1 check_outs("t6_r1", 1'b0, 32'd0, 1'b0, 2'd0, 4'b1000, 1'b1);
        next_cycle();
        in_valid = 4'b0000; in_last = 4'b0000;
        #1 check_outs("t6_r2", 1'b1, 32'hF000_000F, 1'b1, 2'd3, 4'b0000, 1'b0);
        next_cycle();
        #1 check_outs("t6_r3", 1'b0, 32'd0, 1'b0, 2'd0, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rr4_pkt_mux
`default_nettype wire
